// File: rtl/serial_loader_if.sv
// Serial-byte input and memory-write bundle for the framed UART loader.
// The slave modport is the loader side; master is the serial/test side.
interface serial_loader_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned NTGT   = 4
) ();
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [NTGT-1:0]   mem_wren;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err_csum;
  logic              err_timeout;

  modport slave (
    input  rx_byte, rx_ready,
    output mem_addr, mem_data, mem_wren, cpu_hold, busy, done, err_csum, err_timeout
  );

  modport master (
    output rx_byte, rx_ready,
    input  mem_addr, mem_data, mem_wren, cpu_hold, busy, done, err_csum, err_timeout
  );
endinterface

// File: rtl/serial_loader.sv
// Framed UART-to-memory programmer: parses SYNC/CMD/ADDR/LEN/DATA/CSUM frames from
// the serial receiver and writes the payload into one of NTGT memories.
module serial_loader #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned NTGT    = 4,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic            clk,
  input logic            reset_n,
  serial_loader_if.slave bus
);
  localparam int unsigned TgtW = (NTGT > 1) ? $clog2(NTGT) : 1;
  localparam int unsigned GapW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAdl, StAdh, StLnl, StLnh, StData, StCsum
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [TgtW-1:0]   tgt_q, tgt_d;
  logic              run_q, run_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [NTGT-1:0]   wren_q, wren_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_csum_q, err_csum_d;
  logic              err_to_q, err_to_d;

  logic       strobe;
  logic       timeout;
  logic [7:0] csum_sum;
  logic       cmd_bad;

  // sync_q[1:0] is the synchroniser; sync_q[2] delays it for rising-edge detection.
  assign strobe   = sync_q[1] & ~sync_q[2];
  assign timeout  = (state_q != StIdle) && (gap_q == GapW'(TIMEOUT - 1));
  assign csum_sum = csum_q + bus.rx_byte;
  assign cmd_bad  = {25'd0, bus.rx_byte[6:0]} >= NTGT;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    len_d      = len_q;
    csum_d     = csum_q;
    tgt_d      = tgt_q;
    run_d      = run_q;
    gap_d      = (state_q == StIdle) ? '0 : gap_q + GapW'(1);
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wren_d     = '0;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_csum_d = err_csum_q;
    err_to_d   = err_to_q;

    // A timeout wins over a strobe arriving in the same cycle; that byte is lost.
    if (timeout) begin
      err_to_d = 1'b1;
      state_d  = StIdle;
      gap_d    = '0;
    end else if (strobe) begin
      gap_d  = '0;
      csum_d = csum_sum;
      unique case (state_q)
        StIdle: begin
          csum_d = csum_q;
          if (bus.rx_byte == SYNC) begin
            err_csum_d = 1'b0;
            err_to_d   = 1'b0;
            csum_d     = '0;
            state_d    = StCmd;
          end
        end
        StCmd: begin
          if (cmd_bad) begin
            err_csum_d = 1'b1;
            state_d    = StIdle;
          end else begin
            tgt_d   = bus.rx_byte[TgtW-1:0];
            run_d   = bus.rx_byte[7];
            hold_d  = 1'b1;
            state_d = StAdl;
          end
        end
        StAdl: begin
          lo_d    = bus.rx_byte;
          state_d = StAdh;
        end
        StAdh: begin
          addr_d  = ADDR_W'({bus.rx_byte, lo_q});
          state_d = StLnl;
        end
        StLnl: begin
          lo_d    = bus.rx_byte;
          state_d = StLnh;
        end
        StLnh: begin
          len_d   = {bus.rx_byte, lo_q};
          state_d = StData;
        end
        StData: begin
          mem_addr_d = addr_q;
          mem_data_d = bus.rx_byte;
          wren_d     = NTGT'(1) << tgt_q;
          addr_d     = addr_q + ADDR_W'(1);
          if (len_q == 16'd0) begin
            state_d = StCsum;
          end else begin
            len_d = len_q - 16'd1;
          end
        end
        StCsum: begin
          if (csum_sum == 8'd0) begin
            done_d = 1'b1;
            if (run_q) hold_d = 1'b0;
          end else begin
            err_csum_d = 1'b1;
          end
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      addr_q     <= '0;
      lo_q       <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      tgt_q      <= '0;
      run_q      <= 1'b0;
      gap_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      wren_q     <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_csum_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[1:0], bus.rx_ready};
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      tgt_q      <= tgt_d;
      run_q      <= run_d;
      gap_q      <= gap_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wren_q     <= wren_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_csum_q <= err_csum_d;
      err_to_q   <= err_to_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = wren_q;
  assign bus.cpu_hold    = hold_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.err_csum    = err_csum_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: directed frame table, timeout and reset
// sequences, then randomized frames checked against a frame-level model.
module tb_serial_loader;
  localparam int unsigned AW = 14;
  localparam int unsigned NT = 4;
  localparam int unsigned TO = 300;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  serial_loader_if #(.ADDR_W(AW), .NTGT(NT)) bus ();

  serial_loader #(
    .ADDR_W (AW),
    .NTGT   (NT),
    .SYNC   (8'hA5),
    .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wren;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          n;
    bit          bad;
    int          hold;
    logic [3:0]  wren;
    int          nwr;
    bit          done;
    bit          err;
    bit          hold_o;
  } vec_t;

  wr_t        wq[$];
  int         done_cnt = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] frame_q[$];
  logic [7:0] data_q[$];
  vec_t       vt[6];

  always @(negedge clk) begin
    if (bus.mem_wren !== 4'b0000) wq.push_back('{bus.mem_wren, bus.mem_addr, bus.mem_data});
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic build_frame(input logic [7:0] cmd, input logic [15:0] addr, input int n,
                             input bit bad, input bit rnd);
    logic [7:0]  s;
    logic [7:0]  d;
    logic [15:0] len;
    frame_q.delete();
    data_q.delete();
    len = 16'(n - 1);
    frame_q.push_back(8'hA5);
    frame_q.push_back(cmd);
    frame_q.push_back(addr[7:0]);
    frame_q.push_back(addr[15:8]);
    frame_q.push_back(len[7:0]);
    frame_q.push_back(len[15:8]);
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : 8'((i + 1) * 17);
      data_q.push_back(d);
      frame_q.push_back(d);
    end
    s = 8'd0;
    for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
    frame_q.push_back(8'(8'd0 - s) + (bad ? 8'd1 : 8'd0));
  endtask

  task automatic send_frame(input int hold, input int gap);
    wq.delete();
    done_cnt = 0;
    foreach (frame_q[i]) send_byte(frame_q[i], hold, gap);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [3:0] wren, input logic [15:0] base,
                              input int n);
    chk({tag, "_nwrites"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk({tag, "_wren"}, {28'd0, wq[i].wren}, {28'd0, wren});
      chk({tag, "_addr"}, {18'd0, wq[i].addr}, {18'd0, 14'(base + 16'(i))});
      chk({tag, "_data"}, {24'd0, wq[i].data}, {24'd0, data_q[i]});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wren"}, {28'd0, bus.mem_wren}, 32'd0);
    chk({tag, "_addr"}, {18'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, bus.mem_data}, 32'd0);
    chk({tag, "_hold"}, {31'd0, bus.cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_errc"}, {31'd0, bus.err_csum}, 32'd0);
    chk({tag, "_errt"}, {31'd0, bus.err_timeout}, 32'd0);
  endtask

  // Stops after ADDR_HI, expects a timeout; entered with err_csum set from the previous frame.
  task automatic timeout_seq();
    wq.delete();
    send_byte(8'hA5, 1, 3);
    repeat (3) @(negedge clk);
    chk("sync_clears_errc", {31'd0, bus.err_csum}, 32'd0);
    chk("sync_busy", {31'd0, bus.busy}, 32'd1);
    send_byte(8'h00, 1, 3);
    send_byte(8'h00, 1, 3);
    send_byte(8'h00, 1, 3);
    repeat (TO + 20) @(negedge clk);
    chk("to_err", {31'd0, bus.err_timeout}, 32'd1);
    chk("to_busy", {31'd0, bus.busy}, 32'd0);
    chk("to_hold", {31'd0, bus.cpu_hold}, 32'd1);
    chk("to_nwrites", wq.size(), 0);
  endtask

  task automatic reset_seq();
    bit seen;
    build_frame(8'h00, 16'h0100, 4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1, 3);
    bus.rx_byte  = 8'h77;
    bus.rx_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = (bus.mem_wren != 4'b0000);
    end
    chk("rst_wren_seen", {31'd0, seen}, 32'd1);
    chk("rst_wren_val", {28'd0, bus.mem_wren}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit         hold_m;
    int         tgt;
    logic [7:0] cmd;
    logic [15:0] addr;
    int         n;
    bit         bad;
    bit         valid;
    bit         good;

    vt[0] = '{8'h00, 16'hC000, 3, 1'b0, 1,  4'b0001, 3, 1'b1, 1'b0, 1'b1};
    vt[1] = '{8'h82, 16'hC000, 3, 1'b0, 1,  4'b0100, 3, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h05, 16'h0000, 3, 1'b0, 50, 4'b0000, 0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h00, 16'hC000, 3, 1'b1, 1,  4'b0001, 3, 1'b0, 1'b1, 1'b1};
    vt[4] = '{8'h01, 16'h3FFF, 2, 1'b0, 50, 4'b0010, 2, 1'b1, 1'b0, 1'b1};
    vt[5] = '{8'h83, 16'h1234, 1, 1'b0, 1,  4'b1000, 1, 1'b1, 1'b0, 1'b0};

    bus.rx_byte  = 8'h00;
    bus.rx_ready = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      build_frame(vt[i].cmd, vt[i].addr, vt[i].n, vt[i].bad, 1'b0);
      send_frame(vt[i].hold, 3);
      check_writes($sformatf("vec%0d", i), vt[i].wren, vt[i].addr, vt[i].nwr);
      chk($sformatf("vec%0d_done", i), done_cnt, {31'd0, vt[i].done});
      chk($sformatf("vec%0d_errc", i), {31'd0, bus.err_csum}, {31'd0, vt[i].err});
      chk($sformatf("vec%0d_hold", i), {31'd0, bus.cpu_hold}, {31'd0, vt[i].hold_o});
      chk($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("vec%0d_errt", i), {31'd0, bus.err_timeout}, 32'd0);
      if (i == 3) timeout_seq();
    end

    reset_seq();

    hold_m = 1'b0;
    for (int f = 0; f < 30; f++) begin
      tgt   = $urandom_range(0, 4);
      valid = (tgt < 4);
      cmd   = {1'($urandom_range(0, 1)), valid ? 7'(tgt) : 7'($urandom_range(4, 127))};
      addr  = 16'($urandom);
      n     = $urandom_range(1, 8);
      bad   = ($urandom_range(0, 3) == 0);
      build_frame(cmd, addr, n, bad, 1'b1);
      // A rejected target ends the frame; trailing bytes could contain SYNC and restart one.
      if (!valid) while (frame_q.size() > 2) void'(frame_q.pop_back());
      send_frame($urandom_range(1, 6), $urandom_range(3, 6));
      good = valid && !bad;
      if (valid) hold_m = 1'b1;
      if (good && cmd[7]) hold_m = 1'b0;
      check_writes("rnd", valid ? 4'(1 << tgt) : 4'b0000, addr, valid ? n : 0);
      chk("rnd_done", done_cnt, {31'd0, good});
      chk("rnd_errc", {31'd0, bus.err_csum}, {31'd0, !good});
      chk("rnd_hold", {31'd0, bus.cpu_hold}, {31'd0, hold_m});
      chk("rnd_busy", {31'd0, bus.busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
